// File: rtl/nx_ram_1rw_mch.sv
// rtl/nx_ram_1rw_mch.sv - multi-channel 1RW RAM wrapper: round-robin arbitration, masked writes, RD_LAT response pipe, zero-init sweep; optional parity via NX_RAM_PARITY_EN
module nx_ram_1rw_mch #(
  parameter int WIDTH         = 64,
  parameter int DEPTH         = 256,
  parameter int BWEWIDTH      = WIDTH,
  parameter int NUM_CH        = 2,
  parameter int RD_LAT        = 1,
  parameter int INIT_ON_RESET = 1
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [NUM_CH-1:0]                  req_valid,
  output logic [NUM_CH-1:0]                  req_ready,
  input  logic [NUM_CH-1:0]                  req_we,
  input  logic [NUM_CH*$clog2(DEPTH)-1:0]    req_add,
  input  logic [NUM_CH*WIDTH-1:0]            req_din,
  input  logic [NUM_CH*BWEWIDTH-1:0]         req_bwe,
  output logic [NUM_CH-1:0]                  rsp_valid,
  output logic [WIDTH-1:0]                   rsp_dout,
  output logic                               init_done
`ifdef NX_RAM_PARITY_EN
  ,
  input  logic                               par_inject,
  output logic [NUM_CH-1:0]                  rsp_par_err
`endif
);

  localparam int AW  = $clog2(DEPTH);
  localparam int PW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int SEG = WIDTH / BWEWIDTH;

  typedef enum logic [1:0] {
    S_INIT      = 2'd0,
    S_RUN       = 2'd1,
    S_DONE_WAIT = 2'd2
  } state_t;

  state_t           r_state;
  logic [AW-1:0]    r_init_addr;
  logic             r_init_done;
  logic [PW-1:0]    r_ptr;

  logic [WIDTH-1:0] r_mem [DEPTH];

  logic [RD_LAT-1:0] r_pv;
  logic [PW-1:0]     r_pch [RD_LAT];
  logic [WIDTH-1:0]  r_pd  [RD_LAT];

  logic              w_gnt_any;
  logic [PW-1:0]     w_gnt_idx;
  logic [NUM_CH-1:0] w_ready;
  logic              w_we;
  logic [AW-1:0]     w_add;
  logic [WIDTH-1:0]  w_din;
  logic [BWEWIDTH-1:0] w_bwe;
  logic [WIDTH-1:0]  w_mask;
  logic              w_in_range;
  logic [WIDTH-1:0]  w_old;
  logic [WIDTH-1:0]  w_merged;
  logic [WIDTH-1:0]  w_rsp_data;

  // Channel index k steps past the round-robin base, wrapping at NUM_CH.
  function automatic logic [PW-1:0] rr_idx(input logic [PW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NUM_CH) s = s - NUM_CH;
    return PW'(s);
  endfunction

  // Round-robin grant: first valid channel at or after the pointer wins, only in RUN.
  always_comb begin
    w_gnt_any = 1'b0;
    w_gnt_idx = '0;
    w_ready   = '0;
    if (r_state == S_RUN) begin
      for (int k = NUM_CH - 1; k >= 0; k--) begin
        if (req_valid[rr_idx(r_ptr, k)]) begin
          w_gnt_any = 1'b1;
          w_gnt_idx = rr_idx(r_ptr, k);
        end
      end
      if (w_gnt_any) w_ready[w_gnt_idx] = 1'b1;
    end
  end

  assign req_ready = w_ready;

  assign w_we  = req_we[w_gnt_idx];
  assign w_add = req_add[int'(w_gnt_idx)*AW +: AW];
  assign w_din = req_din[int'(w_gnt_idx)*WIDTH +: WIDTH];
  assign w_bwe = req_bwe[int'(w_gnt_idx)*BWEWIDTH +: BWEWIDTH];

  // Each write-enable bit covers SEG consecutive data bits.
  always_comb begin
    w_mask = '0;
    for (int b = 0; b < WIDTH; b++) w_mask[b] = w_bwe[b / SEG];
  end

  generate
    if ((1 << AW) == DEPTH) begin : g_pow2
      assign w_in_range = 1'b1;
    end else begin : g_npow2
      assign w_in_range = (32'(w_add) < DEPTH);
    end
  endgenerate

  // Out-of-range addresses read as zero and never reach the array.
  assign w_old      = w_in_range ? r_mem[w_add] : '0;
  assign w_merged   = (w_old & ~w_mask) | (w_din & w_mask);
  assign w_rsp_data = w_we ? w_merged : w_old;

  // Storage array: init sweep writes zeros, otherwise accepted in-range writes.
  always_ff @(posedge clk) begin
    if (r_state == S_INIT) begin
      r_mem[r_init_addr] <= '0;
    end else if (w_gnt_any && w_we && w_in_range) begin
      r_mem[w_add] <= w_merged;
    end
  end

  // Control FSM: init sweep / startup wait, then RUN with pointer advance on each grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= (INIT_ON_RESET != 0) ? S_INIT : S_DONE_WAIT;
      r_init_addr <= '0;
      r_init_done <= 1'b0;
      r_ptr       <= '0;
    end else begin
      case (r_state)
        S_INIT: begin
          r_init_addr <= r_init_addr + 1'b1;
          if (r_init_addr == AW'(DEPTH - 1)) begin
            r_state     <= S_RUN;
            r_init_done <= 1'b1;
          end
        end
        S_DONE_WAIT: begin
          r_state     <= S_RUN;
          r_init_done <= 1'b1;
        end
        S_RUN: begin
          if (w_gnt_any) begin
            r_ptr <= (w_gnt_idx == PW'(NUM_CH - 1)) ? '0 : w_gnt_idx + 1'b1;
          end
        end
        default: r_state <= S_DONE_WAIT;
      endcase
    end
  end

  assign init_done = r_init_done;

  // Response pipe: stage 0 loads on accept; data stages only move with a valid so the tail holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pv <= '0;
      for (int s = 0; s < RD_LAT; s++) begin
        r_pch[s] <= '0;
        r_pd[s]  <= '0;
      end
    end else begin
      r_pv[0] <= w_gnt_any;
      if (w_gnt_any) begin
        r_pch[0] <= w_gnt_idx;
        r_pd[0]  <= w_rsp_data;
      end
      for (int s = 1; s < RD_LAT; s++) begin
        r_pv[s] <= r_pv[s-1];
        if (r_pv[s-1]) begin
          r_pch[s] <= r_pch[s-1];
          r_pd[s]  <= r_pd[s-1];
        end
      end
    end
  end

  // Decode the tail stage owner into a one-hot response pulse.
  always_comb begin
    rsp_valid = '0;
    if (r_pv[RD_LAT-1]) rsp_valid[r_pch[RD_LAT-1]] = 1'b1;
  end

  assign rsp_dout = r_pd[RD_LAT-1];

`ifdef NX_RAM_PARITY_EN
  logic              r_par [DEPTH];
  logic [RD_LAT-1:0] r_pe;
  logic              w_old_par;
  logic              w_rd_err;

  assign w_old_par = w_in_range ? r_par[w_add] : 1'b0;
  assign w_rd_err  = !w_we && w_in_range && ((^w_old) != w_old_par);

  // Parity array: zero during init, even parity of the merged word (optionally inverted) on write.
  always_ff @(posedge clk) begin
    if (r_state == S_INIT) begin
      r_par[r_init_addr] <= 1'b0;
    end else if (w_gnt_any && w_we && w_in_range) begin
      r_par[w_add] <= (^w_merged) ^ par_inject;
    end
  end

  // Parity error flag travels alongside the response pipe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pe <= '0;
    end else begin
      r_pe[0] <= w_gnt_any && w_rd_err;
      for (int s = 1; s < RD_LAT; s++) r_pe[s] <= r_pe[s-1];
    end
  end

  // Error pulse accompanies the owning channel's response.
  always_comb begin
    rsp_par_err = '0;
    if (r_pv[RD_LAT-1] && r_pe[RD_LAT-1]) rsp_par_err[r_pch[RD_LAT-1]] = 1'b1;
  end
`endif

endmodule

// File: tb/tb_nx_ram_1rw_mch.sv
// tb/tb_nx_ram_1rw_mch.sv - self-checking bench for nx_ram_1rw_mch (two configurations, table + random vs reference model)
module tb_nx_ram_1rw_mch;

  localparam int W  = 64;
  localparam int D  = 12;
  localparam int BW = 8;
  localparam int SG = W / BW;
  localparam int NC = 3;
  localparam int RL = 3;
  localparam int AW = $clog2(D);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NC-1:0]    req_valid, req_ready, req_we, rsp_valid;
  logic [NC*AW-1:0] req_add;
  logic [NC*W-1:0]  req_din;
  logic [NC*BW-1:0] req_bwe;
  logic [W-1:0]     rsp_dout;
  logic             init_done;

  logic        b_rst_n = 1'b0;
  logic [1:0]  b_valid, b_ready, b_we, b_rsp_valid;
  logic [7:0]  b_add;
  logic [63:0] b_din;
  logic [7:0]  b_bwe;
  logic [31:0] b_rsp_dout;
  logic        b_init_done;

`ifdef NX_RAM_PARITY_EN
  logic          par_inject;
  logic [NC-1:0] rsp_par_err;
  logic          b_par_inject;
  logic [1:0]    b_rsp_par_err;
`endif

  nx_ram_1rw_mch #(.WIDTH(W), .DEPTH(D), .BWEWIDTH(BW), .NUM_CH(NC), .RD_LAT(RL), .INIT_ON_RESET(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_add(req_add), .req_din(req_din), .req_bwe(req_bwe), .rsp_valid(rsp_valid),
    .rsp_dout(rsp_dout), .init_done(init_done)
`ifdef NX_RAM_PARITY_EN
    , .par_inject(par_inject), .rsp_par_err(rsp_par_err)
`endif
  );

  nx_ram_1rw_mch #(.WIDTH(32), .DEPTH(16), .BWEWIDTH(4), .NUM_CH(2), .RD_LAT(1), .INIT_ON_RESET(0)) u_dut_b (
    .clk(clk), .rst_n(b_rst_n), .req_valid(b_valid), .req_ready(b_ready), .req_we(b_we),
    .req_add(b_add), .req_din(b_din), .req_bwe(b_bwe), .rsp_valid(b_rsp_valid),
    .rsp_dout(b_rsp_dout), .init_done(b_init_done)
`ifdef NX_RAM_PARITY_EN
    , .par_inject(b_par_inject), .rsp_par_err(b_rsp_par_err)
`endif
  );

  int errs = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic note_timeout(input string name);
    checks++;
    errs++;
    $display("FAIL %s: got timeout expected completion", name);
  endtask

  // Reference model: word array, bad-parity flags, pointer and expected response list.
  typedef struct { int due; int ch; logic [W-1:0] data; bit dchk; bit perr; } rsp_t;
  logic [W-1:0] m_mem [D];
  bit           m_bad [D];
  int           m_ptr;
  bit           m_run;
  int           cyc;
  rsp_t         q[$];
  logic [W-1:0] last_dout;
  bit           last_known;
  logic [NC-1:0] obs_rdy;

  // Pending request per channel (held stable until the model sees it granted).
  bit           p_v [NC];
  bit           p_we [NC];
  int           p_add [NC];
  logic [W-1:0] p_din [NC];
  logic [BW-1:0] p_bwe [NC];
  bit           p_inj [NC];

  typedef struct { int ch; bit we; int add; logic [63:0] din; logic [7:0] bwe; bit inj; bit dchk; logic [63:0] exp; } vec_t;
  vec_t vt [16];

  function automatic int model_grant();
    if (!m_run) return -1;
    for (int k = 0; k < NC; k++) begin
      if (p_v[(m_ptr + k) % NC]) return (m_ptr + k) % NC;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int a = 0; a < D; a++) begin
      m_mem[a] = '0;
      m_bad[a] = 1'b0;
    end
    for (int c = 0; c < NC; c++) p_v[c] = 1'b0;
    q.delete();
    m_ptr = 0;
    m_run = 1'b0;
    last_dout = '0;
    last_known = 1'b1;
  endtask

  task automatic model_accept(input int g);
    logic [W-1:0] m, old, mg;
    bit inr;
    rsp_t e;
    m = '0;
    for (int b = 0; b < BW; b++) if (p_bwe[g][b]) m[b*SG +: SG] = '1;
    inr = (p_add[g] < D);
    old = inr ? m_mem[p_add[g]] : '0;
    e.due = cyc + RL;
    e.ch = g;
    e.perr = 1'b0;
    e.dchk = 1'b1;
    if (p_we[g]) begin
      mg = (old & ~m) | (p_din[g] & m);
      if (inr) begin
        m_mem[p_add[g]] = mg;
        m_bad[p_add[g]] = p_inj[g];
      end else begin
        e.dchk = 1'b0;
      end
      e.data = mg;
    end else begin
      e.data = old;
      e.perr = inr && m_bad[p_add[g]];
    end
    m_ptr = (g + 1) % NC;
    q.push_back(e);
  endtask

  task automatic check_rsp();
    logic [NC-1:0] ev;
    bit has;
    rsp_t e;
    ev = '0;
    has = 1'b0;
    if (q.size() > 0 && q[0].due == cyc) begin
      e = q.pop_front();
      has = 1'b1;
      ev[e.ch] = 1'b1;
    end
    chk("rsp_valid", rsp_valid, ev);
`ifdef NX_RAM_PARITY_EN
    chk("rsp_par_err", rsp_par_err, (has && e.perr) ? ev : '0);
`endif
    if (has) begin
      if (e.dchk) begin
        chk("rsp_dout", rsp_dout, e.data);
        last_dout = e.data;
        last_known = 1'b1;
      end else begin
        last_known = 1'b0;
      end
    end else if (last_known) begin
      chk("rsp_dout_hold", rsp_dout, last_dout);
    end
  endtask

  // One clock: drive pending requests, check grant, advance, check responses.
  task automatic tick();
    int g;
    logic [NC-1:0] exp_rdy;
    g = model_grant();
    for (int c = 0; c < NC; c++) begin
      req_valid[c] = p_v[c];
      req_we[c] = p_we[c];
      req_add[c*AW +: AW] = AW'(p_add[c]);
      req_din[c*W +: W] = p_din[c];
      req_bwe[c*BW +: BW] = p_bwe[c];
    end
`ifdef NX_RAM_PARITY_EN
    par_inject = (g >= 0) ? p_inj[g] : 1'b0;
`endif
    #1;
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    obs_rdy = req_ready;
    chk("req_ready", req_ready, exp_rdy);
    if (g >= 0) begin
      model_accept(g);
      p_v[g] = 1'b0;
    end
    @(posedge clk);
    #1;
    cyc++;
    check_rsp();
  endtask

  task automatic drain(input string name);
    int n;
    for (int c = 0; c < NC; c++) p_v[c] = 1'b0;
    n = 0;
    while (q.size() > 0 && n < 20) begin
      tick();
      n++;
    end
    if (q.size() > 0) note_timeout(name);
  endtask

  task automatic do_vec(input int idx, input vec_t v);
    int n;
    logic [W-1:0] got_d;
    for (int c = 0; c < NC; c++) p_v[c] = 1'b0;
    p_v[v.ch] = 1'b1;
    p_we[v.ch] = v.we;
    p_add[v.ch] = v.add;
    p_din[v.ch] = v.din;
    p_bwe[v.ch] = v.bwe;
    p_inj[v.ch] = v.inj;
    got_d = 'x;
    n = 0;
    while ((p_v[v.ch] || q.size() > 0) && n < 20) begin
      tick();
      if (rsp_valid[v.ch]) got_d = rsp_dout;
      n++;
    end
    if (n >= 20) note_timeout($sformatf("vec%0d", idx));
    else if (v.dchk) chk($sformatf("vec%0d_dout", idx), got_d, v.exp);
  endtask

  // Counts edges from release to init_done; req_ready and rsp_valid must stay low meanwhile.
  task automatic wait_init(input string name);
    int n;
    bit quiet;
    n = 0;
    quiet = 1'b1;
    req_valid = '1;
    while (n < 60) begin
      @(posedge clk);
      #1;
      n++;
      if (init_done) break;
      if (req_ready !== '0 || rsp_valid !== '0) quiet = 1'b0;
    end
    req_valid = '0;
    chk({name, "_cycles"}, 64'(n), 64'(D));
    chk({name, "_quiet"}, 64'(quiet), 64'd1);
    m_run = 1'b1;
  endtask

  task automatic b_txn(input int ch, input bit we, input int add, input logic [31:0] din,
                       input logic [3:0] bwe, input logic [31:0] exp);
    b_valid = '0;
    b_valid[ch] = 1'b1;
    b_we[ch] = we;
    b_add[ch*4 +: 4] = 4'(add);
    b_din[ch*32 +: 32] = din;
    b_bwe[ch*4 +: 4] = bwe;
    #1;
    chk("b_ready", b_ready, 64'(1 << ch));
    @(posedge clk);
    #1;
    b_valid = '0;
    chk("b_rsp_valid", b_rsp_valid, 64'(1 << ch));
    chk("b_rsp_dout", b_rsp_dout, exp);
  endtask

  initial begin
    vt[0]  = '{0, 1'b1, 3,  64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF};
    vt[1]  = '{1, 1'b1, 3,  64'h0,                   8'h0F, 1'b0, 1'b1, 64'hFFFF_FFFF_0000_0000};
    vt[2]  = '{2, 1'b0, 3,  64'h0,                   8'h00, 1'b0, 1'b1, 64'hFFFF_FFFF_0000_0000};
    vt[3]  = '{0, 1'b0, 5,  64'h0,                   8'h00, 1'b0, 1'b1, 64'h0};
    vt[4]  = '{1, 1'b1, 13, 64'hAA,                  8'hFF, 1'b0, 1'b0, 64'h0};
    vt[5]  = '{2, 1'b0, 13, 64'h0,                   8'h00, 1'b0, 1'b1, 64'h0};
    vt[6]  = '{0, 1'b0, 11, 64'h0,                   8'h00, 1'b0, 1'b1, 64'h0};
    vt[7]  = '{1, 1'b1, 11, 64'h1234,                8'h03, 1'b0, 1'b1, 64'h1234};
    vt[8]  = '{2, 1'b0, 11, 64'h0,                   8'h00, 1'b0, 1'b1, 64'h1234};
    vt[9]  = '{0, 1'b1, 0,  64'hDEAD_BEEF_CAFE_F00D, 8'hF0, 1'b0, 1'b1, 64'hDEAD_BEEF_0000_0000};
    vt[10] = '{1, 1'b0, 0,  64'h0,                   8'h00, 1'b0, 1'b1, 64'hDEAD_BEEF_0000_0000};
    vt[11] = '{2, 1'b0, 1,  64'h0,                   8'h00, 1'b0, 1'b1, 64'h0};
    vt[12] = '{0, 1'b1, 7,  64'h0123_4567_89AB_CDEF, 8'hFF, 1'b1, 1'b1, 64'h0123_4567_89AB_CDEF};
    vt[13] = '{1, 1'b0, 7,  64'h0,                   8'h00, 1'b0, 1'b1, 64'h0123_4567_89AB_CDEF};
    vt[14] = '{2, 1'b1, 7,  64'h0123_4567_89AB_CDEF, 8'hFF, 1'b0, 1'b1, 64'h0123_4567_89AB_CDEF};
    vt[15] = '{0, 1'b0, 7,  64'h0,                   8'h00, 1'b0, 1'b1, 64'h0123_4567_89AB_CDEF};

    req_valid = '0; req_we = '0; req_add = '0; req_din = '0; req_bwe = '0;
    b_valid = '0; b_we = '0; b_add = '0; b_din = '0; b_bwe = '0;
`ifdef NX_RAM_PARITY_EN
    par_inject = 1'b0;
    b_par_inject = 1'b0;
`endif
    for (int c = 0; c < NC; c++) begin
      p_we[c] = 1'b0; p_add[c] = 0; p_din[c] = '0; p_bwe[c] = '0; p_inj[c] = 1'b0;
    end
    model_reset();
    cyc = 0;

    // Reset values, with every channel requesting.
    req_valid = '1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", req_ready, '0);
    chk("rst_rsp_valid", rsp_valid, '0);
    chk("rst_rsp_dout", rsp_dout, '0);
    chk("rst_init_done", init_done, 1'b0);

    @(negedge clk);
    rst_n = 1'b1;
    wait_init("init");

    // Round-robin with all channels continuously requesting reads.
    for (int t = 0; t < 7; t++) begin
      for (int c = 0; c < NC; c++) begin
        p_v[c] = 1'b1; p_we[c] = 1'b0; p_add[c] = c; p_inj[c] = 1'b0;
      end
      tick();
      chk($sformatf("rr_order%0d", t), obs_rdy, 64'(1 << (t % 3)));
    end
    for (int c = 0; c < NC; c++) p_v[c] = 1'b0;
    repeat (3) tick();
    for (int c = 0; c < NC; c++) p_v[c] = 1'b1;
    tick();
    chk("rr_hold", obs_rdy, 64'b010);
    drain("rr_drain");

    for (int i = 0; i < 16; i++) do_vec(i, vt[i]);

    // Randomised traffic against the model, including out-of-range addresses.
    for (int t = 0; t < 400; t++) begin
      for (int c = 0; c < NC; c++) begin
        if (!p_v[c] && $urandom_range(0, 3) != 0) begin
          p_v[c] = 1'b1;
          p_we[c] = 1'($urandom_range(0, 1));
          p_add[c] = $urandom_range(0, D + 1);
          p_din[c] = {$urandom, $urandom};
          p_bwe[c] = 8'($urandom);
          p_inj[c] = ($urandom_range(0, 7) == 0);
        end
      end
      tick();
    end
    drain("rand_drain");

    // Reset with a read in flight, then a reset that aborts the init sweep.
    for (int c = 0; c < NC; c++) p_v[c] = 1'b0;
    p_v[0] = 1'b1; p_we[0] = 1'b0; p_add[0] = 0;
    tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rsp_valid", rsp_valid, '0);
    chk("mid_rst_init_done", init_done, 1'b0);
    chk("mid_rst_rsp_dout", rsp_dout, '0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    req_valid = '1;
    repeat (5) @(posedge clk);
    #1;
    chk("abort_init_done", init_done, 1'b0);
    chk("abort_rsp_valid", rsp_valid, '0);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    wait_init("reinit");
    do_vec(100, '{1, 1'b0, 0, 64'h0, 8'h00, 1'b0, 1'b1, 64'h0});
    do_vec(101, '{2, 1'b0, 3, 64'h0, 8'h00, 1'b0, 1'b1, 64'h0});
    drain("final_drain");

    // Second configuration: no init sweep, single-cycle latency, nibble masks.
    @(negedge clk);
    b_rst_n = 1'b1;
    #1;
    chk("b_init_before_edge", b_init_done, 1'b0);
    @(posedge clk);
    #1;
    chk("b_init_after_edge", b_init_done, 1'b1);
    b_txn(1, 1'b1, 7, 32'h1122_3344, 4'hF, 32'h1122_3344);
    b_txn(0, 1'b1, 7, 32'hAABB_CCDD, 4'b0101, 32'h11BB_33DD);
    @(posedge clk);
    #1;
    chk("b_idle_valid", b_rsp_valid, '0);
    chk("b_idle_hold", b_rsp_dout, 32'h11BB_33DD);
    b_rst_n = 1'b0;
    #1;
    chk("b_rst_dout", b_rsp_dout, '0);
    chk("b_rst_init_done", b_init_done, 1'b0);
    @(negedge clk);
    b_rst_n = 1'b1;
    @(posedge clk);
    #1;
    b_txn(1, 1'b0, 7, 32'h0, 4'h0, 32'h11BB_33DD);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
